// File: rtl/id_ex_stage_if.sv
// Decode->execute bus: decoded instruction in, forwarding taps from the
// later stages, and the registered ALU operands out.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // Decode-side handshake and instruction fields
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic [1:0]        in_a_sel;
    logic              in_b_sel;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_we;

    // Forwarding taps, youngest (EX) to oldest (WB)
    logic              fwd_ex_valid;
    logic [REG_AW-1:0] fwd_ex_rd;
    logic [XLEN-1:0]   fwd_ex_val;
    logic              fwd_mem_valid;
    logic [REG_AW-1:0] fwd_mem_rd;
    logic [XLEN-1:0]   fwd_mem_val;
    logic              fwd_mem_pending;
    logic              fwd_wb_valid;
    logic [REG_AW-1:0] fwd_wb_rd;
    logic [XLEN-1:0]   fwd_wb_val;

    // Execute-side handshake and registered operands
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_op;
    logic [XLEN-1:0]   out_a;
    logic [XLEN-1:0]   out_b;
    logic [XLEN-1:0]   out_store;
    logic [XLEN-1:0]   out_pc;
    logic [REG_AW-1:0] out_rd;
    logic              out_rd_we;

    // Environment side: drives decode, forwarding taps and EX ready
    modport master (
        output flush, in_valid, in_op, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_imm, in_a_sel, in_b_sel, in_rd, in_rd_we,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_val, fwd_mem_pending,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_val, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, out_store, out_pc, out_rd, out_rd_we
    );

    // Pipeline register side
    modport slave (
        input  flush, in_valid, in_op, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_imm, in_a_sel, in_b_sel, in_rd, in_rd_we,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
               fwd_mem_valid, fwd_mem_rd, fwd_mem_val, fwd_mem_pending,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_val, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, out_store, out_pc, out_rd, out_rd_we
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register. Forwards source operands at capture,
// stalls on load-use hazards and backpressure, and drops work on flush.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;

    logic              w_rs1_ex, w_rs1_mem, w_rs1_wb;
    logic              w_rs2_ex, w_rs2_mem, w_rs2_wb;
    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_capture;

    logic              r_valid;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_store;
    logic [XLEN-1:0]   r_pc;
    logic [REG_AW-1:0] r_rd;
    logic              r_rd_we;

    assign w_rs1_ex  = bus.fwd_ex_valid  && (bus.fwd_ex_rd  == bus.in_rs1);
    assign w_rs1_mem = bus.fwd_mem_valid && (bus.fwd_mem_rd == bus.in_rs1);
    assign w_rs1_wb  = bus.fwd_wb_valid  && (bus.fwd_wb_rd  == bus.in_rs1);
    assign w_rs2_ex  = bus.fwd_ex_valid  && (bus.fwd_ex_rd  == bus.in_rs2);
    assign w_rs2_mem = bus.fwd_mem_valid && (bus.fwd_mem_rd == bus.in_rs2);
    assign w_rs2_wb  = bus.fwd_wb_valid  && (bus.fwd_wb_rd  == bus.in_rs2);

    // Pick the youngest producer for each source; x0 always reads as zero
    always_comb begin
        w_rs1_fwd = bus.in_rs1_val;
        if (bus.in_rs1 == '0)   w_rs1_fwd = '0;
        else if (w_rs1_ex)      w_rs1_fwd = bus.fwd_ex_val;
        else if (w_rs1_mem)     w_rs1_fwd = bus.fwd_mem_val;
        else if (w_rs1_wb)      w_rs1_fwd = bus.fwd_wb_val;

        w_rs2_fwd = bus.in_rs2_val;
        if (bus.in_rs2 == '0)   w_rs2_fwd = '0;
        else if (w_rs2_ex)      w_rs2_fwd = bus.fwd_ex_val;
        else if (w_rs2_mem)     w_rs2_fwd = bus.fwd_mem_val;
        else if (w_rs2_wb)      w_rs2_fwd = bus.fwd_wb_val;
    end

    // Operand muxes feeding the ALU registers; a_sel of 3 has no meaning
    always_comb begin
        case (bus.in_a_sel)
            2'd0:    w_a = w_rs1_fwd;
            2'd1:    w_a = bus.in_pc;
            2'd2:    w_a = '0;
            default: w_a = 'x;
        endcase
        w_b = bus.in_b_sel ? bus.in_imm : w_rs2_fwd;
    end

    // A pending load in MEM stalls only sources actually consumed and not
    // already supplied by a younger EX result; rs2 counts for stores too
    assign w_rs1_used = (bus.in_a_sel == 2'd0);
    assign w_rs2_used = !bus.in_b_sel || !bus.in_rd_we;
    assign w_hazard   = bus.in_valid && bus.fwd_mem_pending &&
                        ((w_rs1_used && (bus.in_rs1 != '0) && w_rs1_mem && !w_rs1_ex) ||
                         (w_rs2_used && (bus.in_rs2 != '0) && w_rs2_mem && !w_rs2_ex));

    assign w_in_ready = (!r_valid || bus.out_ready) && !w_hazard;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

    // Single-entry buffer: flush beats capture, capture beats drain, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_store <= '0;
            r_pc    <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_op    <= bus.in_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_store <= w_rs2_fwd;
            r_pc    <= bus.in_pc;
            r_rd    <= bus.in_rd;
            r_rd_we <= bus.in_rd_we;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // An offered instruction with the reserved a_sel encoding is a decoder bug
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_valid && (bus.in_a_sel == 2'd3)));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_op    = r_op;
    assign bus.out_a     = r_a;
    assign bus.out_b     = r_b;
    assign bus.out_store = r_store;
    assign bus.out_pc    = r_pc;
    assign bus.out_rd    = r_rd;
    assign bus.out_rd_we = r_rd_we;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use,
// backpressure, flush and operand selection.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge so outputs are sampled off-edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [3:0] op, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [31:0] rs1Val,
                                 input logic [4:0] rs2, input logic [31:0] rs2Val,
                                 input logic [31:0] imm, input logic [1:0] aSel,
                                 input logic bSel, input logic [4:0] rd, input logic rdWe);
        bus.in_valid   = vld;
        bus.in_op      = op;
        bus.in_pc      = pc;
        bus.in_rs1     = rs1;
        bus.in_rs1_val = rs1Val;
        bus.in_rs2     = rs2;
        bus.in_rs2_val = rs2Val;
        bus.in_imm     = imm;
        bus.in_a_sel   = aSel;
        bus.in_b_sel   = bSel;
        bus.in_rd      = rd;
        bus.in_rd_we   = rdWe;
    endtask

    task automatic clearForwarding();
        bus.fwd_ex_valid    = 1'b0;
        bus.fwd_ex_rd       = '0;
        bus.fwd_ex_val      = '0;
        bus.fwd_mem_valid   = 1'b0;
        bus.fwd_mem_rd      = '0;
        bus.fwd_mem_val     = '0;
        bus.fwd_mem_pending = 1'b0;
        bus.fwd_wb_valid    = 1'b0;
        bus.fwd_wb_rd       = '0;
        bus.fwd_wb_val      = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        clearForwarding();
        applyStimulus(1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("reset_op",    {28'b0, bus.out_op},    32'h0);
        checkOutput("reset_a",     bus.out_a,              32'h0);
        checkOutput("reset_store", bus.out_store,          32'h0);
        rst_n = 1'b1;
        tick();

        // Operand select: pc / imm, then zero / imm, then rs1 / rs2 with SUB
        $display("[TB] operand select");
        applyStimulus(1'b1, 4'h0, 32'h100, 5'd1, 32'hAA, 5'd2, 32'hBB, 32'hFFFFFFFC, 2'd1, 1'b1, 5'd3, 1'b1);
        tick();
        checkOutput("sel_valid", {31'b0, bus.out_valid}, 32'h1);
        checkOutput("sel_a_pc",  bus.out_a,     32'h100);
        checkOutput("sel_b_imm", bus.out_b,     32'hFFFFFFFC);
        checkOutput("sel_store", bus.out_store, 32'hBB);
        checkOutput("sel_pc",    bus.out_pc,    32'h100);
        checkOutput("sel_rd",    {27'b0, bus.out_rd}, 32'h3);
        bus.in_a_sel = 2'd2;
        tick();
        checkOutput("sel_a_zero", bus.out_a, 32'h0);
        checkOutput("sel_b_imm2", bus.out_b, 32'hFFFFFFFC);
        applyStimulus(1'b1, 4'h8, 32'h104, 5'd1, 32'hAA, 5'd2, 32'hBB, 32'h4, 2'd0, 1'b0, 5'd4, 1'b1);
        tick();
        checkOutput("sel_a_rs1", bus.out_a,  32'hAA);
        checkOutput("sel_b_rs2", bus.out_b,  32'hBB);
        checkOutput("sel_op",    {28'b0, bus.out_op}, 32'h8);

        // Forwarding priority on rs1: ex > mem > wb > regfile, x0 never forwarded
        $display("[TB] forwarding priority");
        applyStimulus(1'b1, 4'h0, 32'h108, 5'd5, 32'd999, 5'd6, 32'd66, 32'd1, 2'd0, 1'b1, 5'd9, 1'b1);
        bus.fwd_ex_valid  = 1'b1; bus.fwd_ex_rd  = 5'd5; bus.fwd_ex_val  = 32'd111;
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_val = 32'd222;
        bus.fwd_wb_valid  = 1'b1; bus.fwd_wb_rd  = 5'd5; bus.fwd_wb_val  = 32'd333;
        tick();
        checkOutput("fwd_ex",    bus.out_a, 32'd111);
        checkOutput("fwd_b_imm", bus.out_b, 32'd1);
        bus.fwd_ex_valid = 1'b0;
        tick();
        checkOutput("fwd_mem", bus.out_a, 32'd222);
        bus.fwd_mem_valid = 1'b0;
        tick();
        checkOutput("fwd_wb", bus.out_a, 32'd333);
        bus.fwd_wb_valid = 1'b0;
        tick();
        checkOutput("fwd_none", bus.out_a, 32'd999);
        bus.in_rs1 = 5'd0;
        bus.in_rs1_val = 32'd555;
        bus.fwd_ex_valid  = 1'b1; bus.fwd_ex_rd  = 5'd0;
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd0;
        bus.fwd_wb_valid  = 1'b1; bus.fwd_wb_rd  = 5'd0;
        tick();
        checkOutput("fwd_x0", bus.out_a, 32'd0);
        clearForwarding();
        bus.in_rs1 = 5'd5;
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_rd = 5'd6; bus.fwd_ex_val = 32'd77;
        bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd6; bus.fwd_wb_val = 32'd88;
        tick();
        checkOutput("fwd_store_ex", bus.out_store, 32'd77);
        clearForwarding();

        // Load-use stall on rs2, then release when the load data arrives
        $display("[TB] load-use");
        applyStimulus(1'b1, 4'h0, 32'h200, 5'd1, 32'd10, 5'd7, 32'd1, 32'd0, 2'd0, 1'b0, 5'd8, 1'b1);
        bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd7;
        bus.fwd_mem_pending = 1'b1; bus.fwd_mem_val = 32'hDEAD;
        #1;
        checkOutput("lu_stall", {31'b0, bus.in_ready}, 32'h0);
        tick();
        checkOutput("lu_drained", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("lu_stall2",  {31'b0, bus.in_ready},  32'h0);
        bus.fwd_mem_pending = 1'b0; bus.fwd_mem_val = 32'd42;
        #1;
        checkOutput("lu_release", {31'b0, bus.in_ready}, 32'h1);
        tick();
        checkOutput("lu_valid", {31'b0, bus.out_valid}, 32'h1);
        checkOutput("lu_b",     bus.out_b, 32'd42);
        checkOutput("lu_a",     bus.out_a, 32'd10);
        applyStimulus(1'b1, 4'h0, 32'h204, 5'd7, 32'd1, 5'd7, 32'd1, 32'd5, 2'd1, 1'b1, 5'd8, 1'b1);
        bus.fwd_mem_pending = 1'b1;
        #1;
        checkOutput("lu_unused", {31'b0, bus.in_ready}, 32'h1);
        tick();
        checkOutput("lu_unused_a", bus.out_a, 32'h204);
        checkOutput("lu_unused_b", bus.out_b, 32'd5);
        bus.in_b_sel = 1'b0;
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_rd = 5'd7; bus.fwd_ex_val = 32'h99;
        #1;
        checkOutput("lu_ex_override", {31'b0, bus.in_ready}, 32'h1);
        tick();
        checkOutput("lu_ex_b", bus.out_b, 32'h99);
        clearForwarding();

        // Backpressure: A captured, two stall cycles, then B and C in order
        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'h0, 32'hA0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 2'd1, 1'b1, 5'd1, 1'b1);
        tick();
        checkOutput("bp_A", bus.out_pc, 32'hA0);
        bus.in_pc = 32'hB0;
        bus.out_ready = 1'b0;
        #1;
        checkOutput("bp_not_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        checkOutput("bp_hold1_pc", bus.out_pc, 32'hA0);
        checkOutput("bp_hold1_v",  {31'b0, bus.out_valid}, 32'h1);
        tick();
        checkOutput("bp_hold2_pc", bus.out_pc, 32'hA0);
        checkOutput("bp_hold2_a",  bus.out_a,  32'hA0);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_B", bus.out_pc, 32'hB0);
        bus.in_pc = 32'hC0;
        tick();
        checkOutput("bp_C", bus.out_pc, 32'hC0);

        // Flush with a held instruction and a new offer: both vanish
        $display("[TB] flush");
        bus.in_pc = 32'hD0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        tick();
        checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'h0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("flush_valid2", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("flush_dropped", bus.out_pc, 32'hC0);

        // Asynchronous reset while a SUB is stalled in the register
        $display("[TB] reset mid-stall");
        applyStimulus(1'b1, 4'h8, 32'hE0, 5'd1, 32'h1234, 5'd2, 32'd2, 32'd0, 2'd0, 1'b1, 5'd1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        checkOutput("rst_pre_valid", {31'b0, bus.out_valid}, 32'h1);
        checkOutput("rst_pre_op",    {28'b0, bus.out_op},    32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("rst_async_op",    {28'b0, bus.out_op},    32'h0);
        checkOutput("rst_async_a",     bus.out_a,              32'h0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
